tick_processor: RTL and testbench
=================================

// Module: tick_processor
// PURPOSE
//  Parametrised accumulator-style processor core; executes one 16-bit instruction per step tick.
//  Fetches from an external async ROM via address/instruction; holds 8 internal registers and Z/C flags.
//  Adds a built-in step divider (no free-running timer), HALT/resume, BNZ, carry flag and an OUT strobe.
//  Sits between the instruction ROM and the board display/debug logic.
// PARAMETERS
//  DATA_W    16  register/ALU/result width (8..32); imm8 zero-extended to DATA_W
//  ADDR_W     4  program counter width (1..8); ROM depth = 2**ADDR_W
//  STEP_DIV   1  enabled clk cycles per executed instruction (>=1; 1 = every cycle)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  en           in   1       step enable; 0 freezes divider and core state
//  resume       in   1       leaves HALTED (ignored in RUN)
//  instruction  in   16      ROM word at current address, combinational, valid same cycle
//  address      out  ADDR_W  program counter (registered)
//  result       out  DATA_W  last OUT value (registered)
//  out_valid    out  1       1-cycle strobe when result is updated
//  halted       out  1       1 while in HALTED
//  zero_flag    out  1       Z flag
//  carry_flag   out  1       C flag (carry on add, borrow on sub)
// BEHAVIOUR
//  Reset (async, rst_n=0): address=0, result=0, out_valid=0, halted=0, Z=C=0, r0..r7=0, divider=0.
//  Divider: cnt counts 0..STEP_DIV-1 only while en=1; tick = en && cnt==STEP_DIV-1; cnt wraps to 0 on tick.
//  States: RUN, HALTED. RUN: on tick, execute instruction, update pc. HALTED: divider held at 0, no execution.
//  Fields: op=[15:12], rA=[11:9], rB=[8:6], imm8=[7:0], target=[ADDR_W-1:0] of imm8.
//  Opcodes (all take effect on tick edge, pc <= pc+1 mod 2**ADDR_W unless stated):
//   0000 NOP | 0001 LDI rA<=imm8 | 1110 MOV rA<=rB
//   0010 ADD rA<=rA+rB | 1010 ADDI rA<=rA+imm8 : Z=(sum==0), C=carry out of bit DATA_W-1
//   0011 SUB rA<=rA-rB | 1011 SUBI rA<=rA-imm8 : Z=(diff==0), C=borrow (rA < operand, unsigned)
//   1000 JMP pc<=target | 1100 BZ pc<=Z?target:pc+1 | 1101 BNZ pc<=!Z?target:pc+1
//   1111 OUT result<=rA, out_valid=1 next cycle only
//   0100 HALT pc unchanged, -> HALTED, halted=1 from next cycle
//   others: NOP. Flags change only on ADD/ADDI/SUB/SUBI. Results truncated to DATA_W.
//  Branches read Z as it was before the tick (flag from previous arithmetic instruction).
//  HALTED -> RUN when resume=1 (en not required): pc<=pc+1, halted<=0 next cycle; divider restarts from 0.
//  resume in RUN ignored. en=0 mid-divide: cnt holds, resumes count when en returns.
//  pc wrap: address 2**ADDR_W-1 + 1 -> 0. JMP to own address loops forever (legal).
//  out_valid is 0 on every cycle not immediately following an OUT tick.
//  rst_n asserted mid-instruction: all state cleared immediately, no partial writes survive.
// TESTING  (DATA_W=16, ADDR_W=4, STEP_DIV=1 unless stated)
//  1 Reset: rst_n=0 with any instruction -> address=0, result=0, halted=0, out_valid=0, flags 0.
//  2 LDI r1,5; LDI r2,5; SUB r1,r2; BZ 6 -> address 0,1,2,3,6; Z=1, C=0; then BNZ 0 at 6 -> address 7.
//  3 DATA_W=8: LDI r3,0xFF; ADDI r3,0xFF -> r3=0xFE, C=1, Z=0; SUBI r3,0xFF -> r3=0xFF, C=1 (borrow).
//  4 LDI r4,0x2A; OUT r4 -> out_valid=1 for exactly one cycle, result=0x002A, held after.
//  5 HALT at 3 -> address stays 3, halted=1 for 100 cycles; resume pulse -> address 4, halted=0.
//  6 STEP_DIV=4, all NOP: address advances every 4th en=1 cycle; en=0 for 10 cycles freezes; 15 -> 0 wrap.

Source files
------------

// File: rtl/tick_processor.sv
// tick_processor: accumulator-style core executing one 16-bit instruction per
// divided step tick. Eight registers, Z/C flags, HALT/resume, OUT strobe.
// The instruction word comes from an external asynchronous ROM addressed by pc.
module tick_processor #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              resume,
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              halted,
  output logic              zero_flag,
  output logic              carry_flag
);

  // divider needs at least one bit even when every cycle is a tick
  localparam int              CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [7:0][DATA_W-1:0]  regs;

  logic [3:0]        op;
  logic [2:0]        ra_i, rb_i;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] imm, ra_v, rb_v, opnd;
  logic [ADDR_W-1:0] target, pc_inc;
  logic [DATA_W:0]   sum_w, diff_w;

  assign op     = instruction[15:12];
  assign ra_i   = instruction[11:9];
  assign rb_i   = instruction[8:6];
  assign imm8   = instruction[7:0];
  assign imm    = DATA_W'(imm8);
  assign target = imm8[ADDR_W-1:0];
  assign pc_inc = address + ADDR_W'(1);
  assign ra_v   = regs[ra_i];
  assign rb_v   = regs[rb_i];
  // op[3] selects the immediate forms ADDI/SUBI over ADD/SUB
  assign opnd   = op[3] ? imm : rb_v;
  // one extra bit carries the carry-out on add and the borrow on sub
  assign sum_w  = {1'b0, ra_v} + {1'b0, opnd};
  assign diff_w = {1'b0, ra_v} - {1'b0, opnd};

  // divider, RUN/HALTED control and instruction execution on the step tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      regs       <= '0;
      address    <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
      halted     <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (en) begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              cnt     <= '0;
              address <= pc_inc;
              case (op)
                4'h1: regs[ra_i] <= imm;
                4'hE: regs[ra_i] <= rb_v;
                4'h2, 4'hA: begin
                  regs[ra_i] <= sum_w[DATA_W-1:0];
                  zero_flag  <= (sum_w[DATA_W-1:0] == '0);
                  carry_flag <= sum_w[DATA_W];
                end
                4'h3, 4'hB: begin
                  regs[ra_i] <= diff_w[DATA_W-1:0];
                  zero_flag  <= (diff_w[DATA_W-1:0] == '0);
                  carry_flag <= diff_w[DATA_W];
                end
                4'h8: address <= target;
                4'hC: if (zero_flag)  address <= target;
                4'hD: if (!zero_flag) address <= target;
                4'hF: begin
                  result    <= ra_v;
                  out_valid <= 1'b1;
                end
                4'h4: begin
                  address <= address;
                  state   <= HALTED;
                  halted  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        HALTED: begin
          cnt <= '0;
          if (resume) begin
            state   <= RUN;
            halted  <= 1'b0;
            address <= pc_inc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_processor.sv
// Bench for tick_processor: two instances (16-bit/div 1 and 8-bit/div 4) run
// against an instruction-level reference model; directed programs pin the
// model with literal expectations, then random programs and controls follow.
module tb_tick_processor;

  logic        clk;
  logic        rst_n;
  logic        en0, en1, res0, res1;
  logic [15:0] rom16 [16];
  logic [15:0] rom8  [16];

  logic [3:0]  a16, a8;
  logic [15:0] r16;
  logic [7:0]  r8;
  logic        ov16, ov8, h16, h8, z16, z8, c16, c8;

  tick_processor #(.DATA_W(16), .ADDR_W(4), .STEP_DIV(1)) d16 (
    .clk(clk), .rst_n(rst_n), .en(en0), .resume(res0), .instruction(rom16[a16]),
    .address(a16), .result(r16), .out_valid(ov16), .halted(h16),
    .zero_flag(z16), .carry_flag(c16));

  tick_processor #(.DATA_W(8), .ADDR_W(4), .STEP_DIV(4)) d8 (
    .clk(clk), .rst_n(rst_n), .en(en1), .resume(res1), .instruction(rom8[a8]),
    .address(a8), .result(r8), .out_valid(ov8), .halted(h8),
    .zero_flag(z8), .carry_flag(c8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // reference model state, index 0 = 16-bit instance, 1 = 8-bit instance
  int              m_pc [2];
  int              m_cnt [2];
  longint unsigned m_res [2];
  longint unsigned m_regs [2][8];
  bit              m_z [2], m_c [2], m_ov [2], m_h [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_cnt[k] = 0; m_res[k] = 0;
      m_z[k] = 0; m_c[k] = 0; m_ov[k] = 0; m_h[k] = 0;
      for (int i = 0; i < 8; i++) m_regs[k][i] = 0;
    end
  endtask

  // one clock of architectural behaviour for instance k
  task automatic mstep(input int k, input bit e, input bit r, input logic [15:0] ins);
    longint unsigned mask, imm, opnd, s;
    int op, a, b, nxt, sd;
    mask = (k == 0) ? 64'hFFFF : 64'hFF;
    sd   = (k == 0) ? 1 : 4;
    m_ov[k] = 0;
    if (m_h[k]) begin
      if (r) begin
        m_pc[k] = (m_pc[k] + 1) % 16;
        m_h[k] = 0;
        m_cnt[k] = 0;
      end
      return;
    end
    if (!e) return;
    if (m_cnt[k] != sd - 1) begin
      m_cnt[k]++;
      return;
    end
    m_cnt[k] = 0;
    op  = int'(ins[15:12]);
    a   = int'(ins[11:9]);
    b   = int'(ins[8:6]);
    imm = 64'(ins[7:0]);
    nxt = (m_pc[k] + 1) % 16;
    opnd = (op == 2 || op == 3) ? m_regs[k][b] : imm;
    case (op)
      1:  m_regs[k][a] = imm & mask;
      14: m_regs[k][a] = m_regs[k][b];
      2, 10: begin
        s = m_regs[k][a] + opnd;
        m_c[k] = (s > mask);
        s = s & mask;
        m_z[k] = (s == 0);
        m_regs[k][a] = s;
      end
      3, 11: begin
        m_c[k] = (m_regs[k][a] < opnd);
        s = (m_regs[k][a] + mask + 1 - opnd) & mask;
        m_z[k] = (s == 0);
        m_regs[k][a] = s;
      end
      8:  nxt = int'(imm % 16);
      12: if (m_z[k])  nxt = int'(imm % 16);
      13: if (!m_z[k]) nxt = int'(imm % 16);
      15: begin m_res[k] = m_regs[k][a]; m_ov[k] = 1; end
      4:  begin nxt = m_pc[k]; m_h[k] = 1; end
      default: ;
    endcase
    m_pc[k] = nxt;
  endtask

  // compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("d16.address", 32'(a16), 32'(m_pc[0]));
      chk("d16.result",  32'(r16), 32'(m_res[0]));
      chk("d16.out_valid", 32'(ov16), 32'(m_ov[0]));
      chk("d16.halted", 32'(h16), 32'(m_h[0]));
      chk("d16.zero", 32'(z16), 32'(m_z[0]));
      chk("d16.carry", 32'(c16), 32'(m_c[0]));
      chk("d8.address", 32'(a8), 32'(m_pc[1]));
      chk("d8.result",  32'(r8), 32'(m_res[1]));
      chk("d8.out_valid", 32'(ov8), 32'(m_ov[1]));
      chk("d8.halted", 32'(h8), 32'(m_h[1]));
      chk("d8.zero", 32'(z8), 32'(m_z[1]));
      chk("d8.carry", 32'(c8), 32'(m_c[1]));
    end
  end

  // advance one clock; model sees the inputs that were stable at the edge
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      mstep(0, en0, res0, rom16[m_pc[0]]);
      mstep(1, en1, res1, rom8[m_pc[1]]);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    chk_on = 1;
    #1;
    chk("rst.d16.address", 32'(a16), 0);
    chk("rst.d16.result", 32'(r16), 0);
    chk("rst.d16.halted", 32'(h16), 0);
    chk("rst.d16.out_valid", 32'(ov16), 0);
    chk("rst.d16.flags", 32'({z16, c16}), 0);
    chk("rst.d8.address", 32'(a8), 0);
    chk("rst.d8.flags", 32'({z8, c8}), 0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic fill(input bit which, input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (which) rom8[i] = v; else rom16[i] = v;
    end
  endtask

  initial begin
    rst_n = 1'b1; en0 = 1'b0; en1 = 1'b0; res0 = 1'b0; res1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom16[i] = 16'($urandom());
      rom8[i]  = 16'($urandom());
    end
    #2;
    en0 = 1'b1; en1 = 1'b1;
    do_reset();

    // compare, BZ taken, then BNZ not taken
    fill(0, 16'h0000);
    rom16[0] = 16'h1205; rom16[1] = 16'h1405; rom16[2] = 16'h3280;
    rom16[3] = 16'hC006; rom16[6] = 16'hD000;
    do_reset();
    chk("t2.addr0", 32'(a16), 0);
    step(); chk("t2.addr1", 32'(a16), 1);
    step(); chk("t2.addr2", 32'(a16), 2);
    step(); chk("t2.addr3", 32'(a16), 3);
    chk("t2.zero", 32'(z16), 1);
    chk("t2.carry", 32'(c16), 0);
    step(); chk("t2.bz", 32'(a16), 6);
    step(); chk("t2.bnz", 32'(a16), 7);

    // OUT strobe and held result
    fill(0, 16'h0000);
    rom16[0] = 16'h182A; rom16[1] = 16'hF800;
    do_reset();
    step(); step();
    chk("t4.ov_hi", 32'(ov16), 1);
    chk("t4.result", 32'(r16), 32'h2A);
    step();
    chk("t4.ov_lo", 32'(ov16), 0);
    chk("t4.result_held", 32'(r16), 32'h2A);

    // HALT, long idle, resume without en
    fill(0, 16'h0000);
    rom16[3] = 16'h4000;
    do_reset();
    repeat (4) step();
    for (int i = 0; i < 100; i++) begin
      en0 = 1'($urandom_range(0, 1));
      step();
      chk("t5.halt_addr", 32'(a16), 3);
      chk("t5.halted", 32'(h16), 1);
    end
    en0 = 1'b0; res0 = 1'b1;
    step();
    res0 = 1'b0; en0 = 1'b1;
    chk("t5.resume_addr", 32'(a16), 4);
    chk("t5.resume_halted", 32'(h16), 0);
    res0 = 1'b1;
    step();
    res0 = 1'b0;
    chk("t5.resume_in_run", 32'(a16), 5);

    // 8-bit carry and borrow with divide-by-4
    fill(1, 16'h0000);
    rom8[0] = 16'h16FF; rom8[1] = 16'hA6FF; rom8[2] = 16'hF600;
    rom8[3] = 16'hB6FF; rom8[4] = 16'hF600;
    do_reset();
    repeat (8) step();
    chk("t3.add_c", 32'(c8), 1);
    chk("t3.add_z", 32'(z8), 0);
    repeat (4) step();
    chk("t3.sum", 32'(r8), 32'hFE);
    repeat (8) step();
    chk("t3.sub_c", 32'(c8), 1);
    chk("t3.diff", 32'(r8), 32'hFF);

    // divider timing, en freeze mid-count and pc wrap
    fill(1, 16'h0000);
    do_reset();
    repeat (3) step();
    chk("t6.pre_tick", 32'(a8), 0);
    step();
    chk("t6.tick", 32'(a8), 1);
    en1 = 1'b0; repeat (10) step();
    chk("t6.frozen", 32'(a8), 1);
    en1 = 1'b1; repeat (2) step();
    en1 = 1'b0; repeat (3) step();
    en1 = 1'b1; repeat (2) step();
    chk("t6.held_count", 32'(a8), 2);
    repeat (52) step();
    chk("t6.addr15", 32'(a8), 15);
    repeat (4) step();
    chk("t6.wrap", 32'(a8), 0);

    // random programs, enables, resumes and occasional resets
    for (int round = 0; round < 40; round++) begin
      for (int i = 0; i < 16; i++) begin
        rom16[i] = 16'($urandom());
        rom8[i]  = 16'($urandom());
      end
      for (int c = 0; c < 200; c++) begin
        en0  = ($urandom_range(0, 99) < 85);
        en1  = ($urandom_range(0, 99) < 85);
        res0 = ($urandom_range(0, 99) < 10);
        res1 = ($urandom_range(0, 99) < 10);
        if ($urandom_range(0, 199) == 0) do_reset();
        else step();
      end
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
